// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch front-end feeding the IF/ID register.
// Issues in-order word fetches, buffers {pc,instr} pairs in a DEPTH-entry
// FIFO, and discards in-flight responses after a redirect.
// Optional feature: define FQ_BYPASS_EN to let a response reach out_* in the
// same cycle it returns when the queue is empty and nothing is being dropped.
//
// Handshakes: out_valid/out_ready is a standard valid/ready pair. An entry
// transfers on a cycle where both are high, and out_valid never depends on
// out_ready. ireq has no backpressure, so every cycle with ireq=1 is a fetch.
// ivalid marks one in-order response per earlier fetch.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] iaddr,
  output logic        ireq,
  input  logic [31:0] idata,
  input  logic        ivalid,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        o_dbg_state
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_t;

  state_t        r_state;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_resp_pc;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_drop;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [31:0]   r_q_pc    [DEPTH];
  logic [31:0]   r_q_instr [DEPTH];

  logic [CW:0]   w_inflight;
  logic          w_issue;
  logic          w_head_valid;
  logic          w_resp_keep;
  logic          w_resp_drop;
  logic          w_bypass;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_out_next;
  logic [CW-1:0] w_drop_next;
  logic [31:0]   w_redirect_pc;
  logic          w_unused_pc_lsb;

  // The low two bits of the redirect target are dropped (word aligned fetch).
  assign w_redirect_pc   = {redirect_pc[31:2], 2'b00};
  assign w_unused_pc_lsb = ^redirect_pc[1:0];

  // Entries held plus fetches in flight must never exceed the queue size,
  // which is what makes overflow impossible without any backpressure.
  assign w_inflight   = {1'b0, r_count} + {1'b0, r_outstanding};
  assign w_issue      = rst & ~redirect & (w_inflight < (CW+1)'(DEPTH));
  assign w_head_valid = (r_count != '0);

  // A response is either stale (pre-redirect) or a real entry.
  assign w_resp_drop = ivalid & (redirect | (r_drop != '0));
  assign w_resp_keep = ivalid & ~redirect & (r_drop == '0);

`ifdef FQ_BYPASS_EN
  // Empty queue: present the returning word directly to decode.
  assign w_bypass = rst & w_resp_keep & ~w_head_valid;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_pop  = w_head_valid & out_ready & ~redirect;
  assign w_push = w_resp_keep & ~(w_bypass & out_ready);

  assign w_out_next  = r_outstanding + CW'(w_issue) - CW'(ivalid);
  assign w_drop_next = redirect    ? w_out_next :
                       w_resp_drop ? (r_drop - CW'(1)) : r_drop;

  assign ireq        = w_issue;
  assign iaddr       = r_fetch_pc;
  assign out_valid   = w_head_valid | w_bypass;
  assign out_pc      = w_bypass ? r_resp_pc : r_q_pc[r_rd_ptr];
  assign out_instr   = w_bypass ? idata     : r_q_instr[r_rd_ptr];
  assign o_dbg_state = r_state;

  // RUN/FLUSH tracker: FLUSH while stale responses are still expected.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_RUN;
    end else if (redirect) begin
      r_state <= (w_drop_next != '0) ? ST_FLUSH : ST_RUN;
    end else if ((r_state == ST_FLUSH) && (w_drop_next == '0)) begin
      r_state <= ST_RUN;
    end
  end

  // Fetch/response pointers and occupancy counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_count       <= '0;
      r_outstanding <= '0;
      r_drop        <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
    end else begin
      r_outstanding <= w_out_next;
      r_drop        <= w_drop_next;
      if (redirect) begin
        r_fetch_pc <= w_redirect_pc;
        r_resp_pc  <= w_redirect_pc;
        r_count    <= '0;
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
      end else begin
        if (w_issue)     r_fetch_pc <= r_fetch_pc + 32'd4;
        if (w_resp_keep) r_resp_pc  <= r_resp_pc + 32'd4;
        if (w_push)      r_wr_ptr   <= r_wr_ptr + AW'(1);
        if (w_pop)       r_rd_ptr   <= r_rd_ptr + AW'(1);
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  // Queue storage; cleared on reset so out_* read as zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_q_pc[i]    <= '0;
        r_q_instr[i] <= '0;
      end
    end else if (w_push && !redirect) begin
      r_q_pc[r_wr_ptr]    <= r_resp_pc;
      r_q_instr[r_wr_ptr] <= idata;
    end
  end

`ifndef SYNTHESIS
  // A response without a matching fetch is a memory protocol error.
  a_no_orphan_resp: assert property (@(posedge clk) disable iff (!rst)
    ivalid |-> (r_outstanding != '0));
`endif

endmodule
